// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_pkg
//  Description : Shared TMDS definitions: control-token codes (also used by
//                the encoder side), decoder alignment FSM states and the
//                symbol token-class type.
//  Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

    // Control tokens as q[9:0], MSB first; index is {C1,C0}
    localparam logic [9:0] c_CTL_TOKEN_00 = 10'h354;
    localparam logic [9:0] c_CTL_TOKEN_01 = 10'h0AB;
    localparam logic [9:0] c_CTL_TOKEN_10 = 10'h154;
    localparam logic [9:0] c_CTL_TOKEN_11 = 10'h2AB;

    // Word-alignment FSM states, explicitly encoded
    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } tmds_state_t;

    // Class of a received symbol
    typedef enum logic {
        TOK_DATA = 1'b0,
        TOK_CTL  = 1'b1
    } tok_class_t;

endpackage
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_symbol_decode
//  Description : Purely combinational decode of one 10-bit TMDS symbol.
//                Classifies the symbol as control token or data and produces
//                both interpretations; the caller picks via o_is_ctl.
//  Ports       : i_symbol  [9:0]  received symbol q[9:0]
//                o_data    [7:0]  data byte (inversion + XOR/XNOR undone)
//                o_ctl     [1:0]  {C1,C0} when the symbol is a token, else 0
//                o_is_ctl         1 = symbol is one of the four tokens
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] i_symbol,
    output logic [7:0] o_data,
    output logic [1:0] o_ctl,
    output logic       o_is_ctl
);

    logic [7:0] w_d;

    // q[9] marks a DC-balance inversion of the low byte
    assign w_d = i_symbol[9] ? ~i_symbol[7:0] : i_symbol[7:0];

    // q[8] selects whether the encoder chained with XOR (1) or XNOR (0)
    always_comb begin
        o_data    = '0;
        o_data[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            o_data[i] = i_symbol[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_comb begin
        o_is_ctl = 1'b1;
        o_ctl    = 2'b00;
        case (i_symbol)
            c_CTL_TOKEN_00: o_ctl = 2'b00;
            c_CTL_TOKEN_01: o_ctl = 2'b01;
            c_CTL_TOKEN_10: o_ctl = 2'b10;
            c_CTL_TOKEN_11: o_ctl = 2'b11;
            default:        o_is_ctl = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder
//  Description : One-channel TMDS receive decoder. Two-stage pipeline
//                (decode/classify, then output register) plus a word
//                alignment FSM that requests bit slips until a run of
//                control tokens is seen, then reports lock.
//  Ports       : clk_in           pixel clock
//                rst_n_in         asynchronous active-low reset
//                symbol_in [9:0]  deserialized symbol, bit 0 first on wire
//                symbol_valid_in  symbol_in qualifier
//                data_out  [7:0]  decoded pixel byte (de_out = 1)
//                control_out [1:0] decoded {C1,C0} (de_out = 0)
//                de_out           1 = data symbol, 0 = control token
//                valid_out        output qualifier, only while locked
//                bitslip_out      1-clock slip request to the deserializer
//                locked_out       word alignment achieved
//  Revision    : 1.0 - initial release
// ============================================================================
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT       = 8,
    parameter int SEARCH_TIMEOUT   = 2048,
    parameter int UNLOCK_TIMEOUT   = 4096,
    parameter int SLIP_WAIT_CYCLES = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [9:0] symbol_in,
    input  logic       symbol_valid_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       bitslip_out,
    output logic       locked_out
);

    localparam int c_TOK_W  = $clog2(LOCK_COUNT + 1);
    localparam int c_TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
    localparam int c_IDLE_W = $clog2(UNLOCK_TIMEOUT + 1);
    localparam int c_WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

    localparam logic [c_TOK_W-1:0]  c_TOK_MAX  = c_TOK_W'(LOCK_COUNT);
    localparam logic [c_TMO_W-1:0]  c_TMO_MAX  = c_TMO_W'(SEARCH_TIMEOUT);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(UNLOCK_TIMEOUT);
    // Last value of the wait counter before leaving SLIP_WAIT
    localparam logic [c_WAIT_W-1:0] c_WAIT_END = c_WAIT_W'(SLIP_WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Stage-1 decode of the incoming symbol
    // ------------------------------------------------------------------
    logic [7:0] w_dec_data;
    logic [1:0] w_dec_ctl;
    logic       w_dec_is_ctl;

    tmds_symbol_decode u_symbol_decode (
        .i_symbol (symbol_in),
        .o_data   (w_dec_data),
        .o_ctl    (w_dec_ctl),
        .o_is_ctl (w_dec_is_ctl)
    );

    logic       r_s1_valid;
    logic [7:0] r_s1_data;
    logic [1:0] r_s1_ctl;
    tok_class_t r_s1_cls;

    // ------------------------------------------------------------------
    // Alignment FSM state and counters
    // ------------------------------------------------------------------
    tmds_state_t         r_state,    w_state_nxt;
    logic [c_TOK_W-1:0]  r_tok_cnt,  w_tok_nxt,  w_tok_inc;
    logic [c_TMO_W-1:0]  r_tmo_cnt,  w_tmo_nxt,  w_tmo_inc;
    logic [c_IDLE_W-1:0] r_idle_cnt, w_idle_nxt, w_idle_inc;
    logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
    logic                w_slip_nxt;
    logic                w_locked_nxt;

    // Saturating increments: counters never wrap past their thresholds
    assign w_tok_inc  = (r_tok_cnt  == c_TOK_MAX)  ? r_tok_cnt  : r_tok_cnt  + c_TOK_W'(1);
    assign w_tmo_inc  = (r_tmo_cnt  == c_TMO_MAX)  ? r_tmo_cnt  : r_tmo_cnt  + c_TMO_W'(1);
    assign w_idle_inc = (r_idle_cnt == c_IDLE_MAX) ? r_idle_cnt : r_idle_cnt + c_IDLE_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_tok_nxt   = r_tok_cnt;
        w_tmo_nxt   = r_tmo_cnt;
        w_idle_nxt  = r_idle_cnt;
        w_wait_nxt  = r_wait_cnt;
        w_slip_nxt  = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (r_s1_valid) begin
                    w_tok_nxt = (r_s1_cls == TOK_CTL) ? w_tok_inc : '0;
                    w_tmo_nxt = w_tmo_inc;
                    // Lock is tested first so it wins over a coincident timeout
                    if (w_tok_nxt == c_TOK_MAX) begin
                        w_state_nxt = ST_LOCKED;
                        w_tok_nxt   = '0;
                        w_tmo_nxt   = '0;
                        w_idle_nxt  = '0;
                    end else if (w_tmo_nxt == c_TMO_MAX) begin
                        w_state_nxt = ST_SLIP_WAIT;
                        w_slip_nxt  = 1'b1;
                        w_wait_nxt  = '0;
                        w_tok_nxt   = '0;
                        w_tmo_nxt   = '0;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                // Counts clocks, not symbols: the deserializer is realigning
                if (r_wait_cnt == c_WAIT_END) begin
                    w_state_nxt = ST_SEARCH;
                    w_wait_nxt  = '0;
                    w_tok_nxt   = '0;
                    w_tmo_nxt   = '0;
                end else begin
                    w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
                end
            end
            ST_LOCKED: begin
                if (r_s1_valid) begin
                    w_idle_nxt = (r_s1_cls == TOK_CTL) ? '0 : w_idle_inc;
                    if (w_idle_nxt == c_IDLE_MAX) begin
                        w_state_nxt = ST_SEARCH;
                        w_tok_nxt   = '0;
                        w_tmo_nxt   = '0;
                        w_idle_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
                w_tok_nxt   = '0;
                w_tmo_nxt   = '0;
                w_idle_nxt  = '0;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // The symbol that completes lock is itself emitted as valid, and the
    // one that drops lock is not, so gate on the post-transition lock state.
    assign w_locked_nxt = (w_state_nxt == ST_LOCKED);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0] r_data;
    logic [1:0] r_ctl;
    logic       r_de;
    logic       r_valid;
    logic       r_bitslip;
    logic       r_locked;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_ctl   <= '0;
            r_s1_cls   <= TOK_DATA;
            r_state    <= ST_SEARCH;
            r_tok_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_idle_cnt <= '0;
            r_wait_cnt <= '0;
            r_data     <= '0;
            r_ctl      <= '0;
            r_de       <= 1'b0;
            r_valid    <= 1'b0;
            r_bitslip  <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            // Stage 1
            r_s1_valid <= symbol_valid_in;
            r_s1_data  <= w_dec_data;
            r_s1_ctl   <= w_dec_ctl;
            r_s1_cls   <= w_dec_is_ctl ? TOK_CTL : TOK_DATA;

            // FSM
            r_state    <= w_state_nxt;
            r_tok_cnt  <= w_tok_nxt;
            r_tmo_cnt  <= w_tmo_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_bitslip  <= w_slip_nxt;
            r_locked   <= w_locked_nxt;

            // Stage 2: fields keep updating while unlocked for debug visibility;
            // each symbol class only overwrites its own field.
            r_valid <= r_s1_valid & w_locked_nxt;
            if (r_s1_valid) begin
                r_de <= (r_s1_cls == TOK_DATA);
                if (r_s1_cls == TOK_DATA) begin
                    r_data <= r_s1_data;
                end else begin
                    r_ctl <= r_s1_ctl;
                end
            end
        end
    end

    assign data_out    = r_data;
    assign control_out = r_ctl;
    assign de_out      = r_de;
    assign valid_out   = r_valid;
    assign bitslip_out = r_bitslip;
    assign locked_out  = r_locked;

endmodule
`default_nettype wire
